// File: rtl/addsub_arbiter.sv
// Round-robin front end that time-shares one adder/subtractor among N_REQ requesters.
// Accepts one operation per cycle and returns the tagged result two cycles later.

module adder_substractor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             select_i,
  output logic [WIDTH-1:0] bus_o,
  output logic             flag_v_o
);
  logic operands_differ;
  logic result_sign_flip;

  assign bus_o = select_i ? (a_i - b_i) : (a_i + b_i);
  assign operands_differ  = a_i[WIDTH-1] ^ b_i[WIDTH-1];
  assign result_sign_flip = bus_o[WIDTH-1] ^ a_i[WIDTH-1];
  // Add overflows on like signs, subtract on unlike signs, when the result sign leaves A's.
  assign flag_v_o = result_sign_flip & (select_i ? operands_differ : ~operands_differ);
endmodule

module addsub_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*WIDTH-1:0] req_a_i,
  input  logic [N_REQ*WIDTH-1:0] req_b_i,
  input  logic [N_REQ-1:0]       req_sub_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [WIDTH-1:0]       rsp_bus_o,
  output logic                   rsp_flag_v_o
);
  localparam logic [ID_W:0]   N_REQ_W = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];

  logic [ID_W-1:0]  prio_reg;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W:0]    cand_sum;
  logic [ID_W-1:0]  cand_idx;
  logic             grant_any;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic             s1_sub_reg;
  logic [ID_W-1:0]  s1_id_reg;

  logic [N_REQ-1:0] rsp_valid_reg;
  logic [ID_W-1:0]  rsp_id_reg;
  logic [WIDTH-1:0] rsp_bus_reg;
  logic             rsp_flag_reg;

  logic [WIDTH-1:0] exec_bus;
  logic             exec_flag;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign a_arr[gi]       = req_a_i[gi*WIDTH +: WIDTH];
      assign b_arr[gi]       = req_b_i[gi*WIDTH +: WIDTH];
      assign req_ready_o[gi] = grant_any && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // Scan from lowest priority to highest so the highest-priority valid requester wins.
  always_comb begin
    grant_idx = prio_reg;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      cand_sum = {1'b0, prio_reg} + (ID_W+1)'(j);
      cand_idx = (cand_sum >= N_REQ_W) ? ID_W'(cand_sum - N_REQ_W) : ID_W'(cand_sum);
      if (req_valid_i[cand_idx]) begin
        grant_idx = cand_idx;
      end
    end
  end

  assign grant_any = (|req_valid_i) && !rst_i;

  adder_substractor #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a_i      (s1_a_reg),
    .b_i      (s1_b_reg),
    .select_i (s1_sub_reg),
    .bus_o    (exec_bus),
    .flag_v_o (exec_flag)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_reg      <= '0;
      s1_valid_reg  <= 1'b0;
      rsp_valid_reg <= '0;
      rsp_id_reg    <= '0;
      rsp_bus_reg   <= '0;
      rsp_flag_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= grant_any;
      if (grant_any) begin
        prio_reg <= (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
      end
      rsp_valid_reg <= '0;
      if (s1_valid_reg) begin
        rsp_valid_reg[s1_id_reg] <= 1'b1;
        rsp_id_reg               <= s1_id_reg;
        rsp_bus_reg              <= exec_bus;
        rsp_flag_reg             <= exec_flag;
      end
    end
  end

  // Operand registers are only meaningful while s1_valid_reg is set, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (grant_any) begin
      s1_a_reg   <= a_arr[grant_idx];
      s1_b_reg   <= b_arr[grant_idx];
      s1_sub_reg <= req_sub_i[grant_idx];
      s1_id_reg  <= grant_idx;
    end
  end

  // A pulse already in the output register is suppressed while reset is high,
  // so operations caught by a reset never surface.
  assign rsp_valid_o  = rsp_valid_reg & {N_REQ{~rst_i}};
  assign rsp_id_o     = rsp_id_reg;
  assign rsp_bus_o    = rsp_bus_reg;
  assign rsp_flag_v_o = rsp_flag_reg;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: a driver issues operations and queues the
// expected responses, a monitor pops and compares whenever a response pulse appears.

module tb_addsub_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_sub;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_bus;
  logic           rsp_flag;

  addsub_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_sub_i    (req_sub),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_id_o     (rsp_id),
    .rsp_bus_o    (rsp_bus),
    .rsp_flag_v_o (rsp_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         id;
    logic [W-1:0] bus;
    logic       flag;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int passes = 0;

  // Reference model state: pending operations per requester and the priority pointer.
  bit           pend [N];
  logic [W-1:0] ma [N];
  logic [W-1:0] mb [N];
  bit           msub [N];
  int           prio_m;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endfunction

  // Signed arithmetic on integers, then wrap; overflow means the true value is out of range.
  function automatic exp_t model_op(int id, logic [W-1:0] a, logic [W-1:0] b, bit s, int due);
    exp_t   e;
    longint sa, sb, r;
    longint lo, hi;
    sa = longint'(a);
    sb = longint'(b);
    if (a >= (1 << (W-1))) sa = sa - (longint'(1) << W);
    if (b >= (1 << (W-1))) sb = sb - (longint'(1) << W);
    r  = s ? (sa - sb) : (sa + sb);
    lo = -(longint'(1) << (W-1));
    hi = (longint'(1) << (W-1)) - 1;
    e.due  = due;
    e.id   = id;
    e.flag = (r < lo) || (r > hi);
    e.bus  = r[W-1:0];
    return e;
  endfunction

  task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b, bit s);
    pend[i] = 1'b1;
    ma[i]   = a;
    mb[i]   = b;
    msub[i] = s;
  endtask

  task automatic refill_random(int i);
    if (!pend[i]) set_op(i, W'($urandom), W'($urandom), 1'($urandom));
  endtask

  // One cycle: apply inputs after the edge, check the grant, update the model.
  task automatic drive(input bit r);
    int g;
    @(posedge clk);
    #1;
    rst = r;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend[i];
      req_a[i*W +: W]    = ma[i];
      req_b[i*W +: W]    = mb[i];
      req_sub[i]         = msub[i];
    end
    g = -1;
    if (!r) begin
      for (int o = 0; o < N; o++) begin
        int k;
        k = (prio_m + o) % N;
        if (pend[k] && g < 0) g = k;
      end
    end
    #1;
    check("ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    if (r) begin
      prio_m = 0;
      for (int j = sbq.size() - 1; j >= 0; j--) begin
        if (sbq[j].due >= cyc) sbq.delete(j);
      end
    end else if (g >= 0) begin
      sbq.push_back(model_op(g, ma[g], mb[g], msub[g], cyc + 2));
      pend[g] = 1'b0;
      prio_m  = (g + 1) % N;
    end
  endtask

  // Monitor: compares every response pulse against the queue head and checks hold behaviour.
  logic [W-1:0]  last_bus  = '0;
  logic [IW-1:0] last_id   = '0;
  logic          last_flag = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        last_bus  = '0;
        last_id   = '0;
        last_flag = 1'b0;
      end else if (rsp_valid != '0) begin
        if (sbq.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = sbq.pop_front();
          $display("rsp cycle=%0d id=%0d bus=%0h flag=%0b", cyc, rsp_id, rsp_bus, rsp_flag);
          check("rsp_cycle", 64'(cyc), 64'(e.due));
          check("rsp_onehot", 64'(rsp_valid), 64'd1 << e.id);
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_bus", 64'(rsp_bus), 64'(e.bus));
          check("rsp_flag", 64'(rsp_flag), 64'(e.flag));
          last_bus  = e.bus;
          last_id   = IW'(e.id);
          last_flag = e.flag;
        end
      end else begin
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
          check("missed_rsp", 64'(rsp_valid), 64'd1 << sbq[0].id);
          void'(sbq.pop_front());
        end
        check("hold_bus", 64'(rsp_bus), 64'(last_bus));
        check("hold_id", 64'(rsp_id), 64'(last_id));
        check("hold_flag", 64'(rsp_flag), 64'(last_flag));
      end
    end
  end

  initial begin
    logic [W-1:0] ov_a [3];
    logic [W-1:0] ov_b [3];
    bit           ov_s [3];
    logic [W-1:0] ov_bus [3];
    bit           ov_flag [3];
    int           order_c [5];
    int           order_rr [4];

    ov_a = '{8'h80, 8'h7F, 8'h03};
    ov_b = '{8'h01, 8'h01, 8'h05};
    ov_s = '{1'b1, 1'b0, 1'b1};
    ov_bus = '{8'h7F, 8'h80, 8'hFE};
    ov_flag = '{1'b1, 1'b1, 1'b0};
    order_c = '{0, 1, 2, 3, 0};
    order_rr = '{1, 3, 1, 3};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_sub = '0;
    prio_m = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      ma[i] = '0;
      mb[i] = '0;
      msub[i] = 1'b0;
    end

    repeat (3) drive(1'b1);
    drive(1'b0);
    check("reset_valid", 64'(rsp_valid), 64'd0);
    check("reset_id", 64'(rsp_id), 64'd0);
    check("reset_bus", 64'(rsp_bus), 64'd0);
    check("reset_flag", 64'(rsp_flag), 64'd0);

    // Single add on requester 2
    set_op(2, 8'h05, 8'h03, 1'b0);
    drive(1'b0);
    check("single_ready", 64'(req_ready), 64'b0100);
    drive(1'b0);
    drive(1'b0);
    check("single_valid", 64'(rsp_valid), 64'b0100);
    check("single_id", 64'(rsp_id), 64'd2);
    check("single_bus", 64'(rsp_bus), 64'h08);
    check("single_flag", 64'(rsp_flag), 64'd0);

    // Overflow corners, back to back on requester 0
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_op(0, ov_a[i], ov_b[i], ov_s[i]);
      drive(1'b0);
      if (i >= 2) begin
        check("ovf_bus", 64'(rsp_bus), 64'(ov_bus[i-2]));
        check("ovf_flag", 64'(rsp_flag), 64'(ov_flag[i-2]));
      end
    end

    // Full contention from reset
    drive(1'b1);
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < N; r++) refill_random(r);
      drive(1'b0);
      check("contend_ready", 64'(req_ready), 64'd1 << order_c[i]);
    end
    repeat (3) drive(1'b0);

    // Last grant was 3; only requesters 1 and 3 stay valid
    for (int i = 0; i < 4; i++) begin
      refill_random(1);
      refill_random(3);
      drive(1'b0);
      check("rr_skip_ready", 64'(req_ready), 64'd1 << order_rr[i]);
    end
    repeat (2) drive(1'b0);

    // Reset flush
    drive(1'b1);
    set_op(0, W'($urandom), W'($urandom), 1'($urandom));
    drive(1'b0);
    check("flush_accept", 64'(req_ready), 64'b0001);
    drive(1'b1);
    set_op(1, W'($urandom), W'($urandom), 1'($urandom));
    set_op(0, W'($urandom), W'($urandom), 1'($urandom));
    drive(1'b0);
    check("flush_first", 64'(req_ready), 64'b0001);
    repeat (4) drive(1'b0);

    // Idle gap
    for (int i = 0; i < 5; i++) begin
      drive(1'b0);
      check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    for (int r = 0; r < N; r++) refill_random(r);
    drive(1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 1) == 1) refill_random(r);
      end
      drive($urandom_range(0, 49) == 0);
    end

    for (int r = 0; r < N; r++) pend[r] = 1'b0;
    repeat (4) drive(1'b0);
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
